// File: rtl/power_seq_ctrl_pkg.sv
// Shared types for the PMIC rail sequencer: FSM states, fault codes, rail-index helpers.
package power_seq_ctrl_pkg;

    localparam int unsigned IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP_WAIT = 3'd1,
        ST_PG_WAIT = 3'd2,
        ST_ON      = 3'd3,
        ST_DN_WAIT = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'b00,
        FLT_TIMEOUT = 2'b01,
        FLT_PGLOST  = 2'b10
    } fault_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [7:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/power_seq_ctrl_seq_delay_timer.sv
// Shared delay/timeout up-counter with synchronous clear and count enable.
module seq_delay_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/power_seq_ctrl.sv
// PMIC power sequencer: ordered rail enable with per-rail delay and pgood check,
// reverse-order power-down, and latched fault reporting.
module power_seq_ctrl
    import power_seq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_RAILS  = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned PG_TIMEOUT = 200
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       fault_clr,
    input  logic [NUM_RAILS*CNT_W-1:0] delay_cfg,
    input  logic [NUM_RAILS-1:0]       pgood,
    output logic [NUM_RAILS-1:0]       rail_en,
    output logic                       busy,
    output logic                       up,
    output logic                       fault,
    output logic [1:0]                 fault_code,
    output logic [2:0]                 fault_rail
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

    state_e                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [NUM_RAILS-1:0]   rail_en_nxt;
    fault_e                 code_nxt;
    logic [2:0]             frail_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       delay_sel_c;
    logic [NUM_RAILS-1:0]   sel_mask_c;
    logic [NUM_RAILS-1:0]   lost_c;
    logic                   dly_hit_c, tmo_hit_c, pg_sel_c, lost_any_c;
    logic                   go_fault_c, cnt_clr_c, cnt_en_c;

    seq_delay_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr_c),
        .en    (cnt_en_c),
        .count (cnt)
    );

    // Per-rail selection and pgood-loss detection for the current index.
    always_comb begin
        sel_mask_c  = NUM_RAILS'(1) << idx;
        delay_sel_c = CNT_W'(delay_cfg >> (idx * CNT_W));
        dly_hit_c   = (cnt == delay_sel_c);
        tmo_hit_c   = (cnt == CNT_W'(PG_TIMEOUT));
        pg_sel_c    = |(pgood & sel_mask_c);
        lost_c      = rail_en & ~pgood;
        if (state == ST_PG_WAIT) lost_c = lost_c & ~sel_mask_c;
        lost_any_c  = (state inside {ST_UP_WAIT, ST_PG_WAIT, ST_ON}) && (|lost_c);
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        rail_en_nxt = rail_en;
        code_nxt    = fault_e'(fault_code);
        frail_nxt   = fault_rail;
        go_fault_c  = 1'b0;
        cnt_en_c    = 1'b0;

        if (lost_any_c) begin
            go_fault_c = 1'b1;
            code_nxt   = FLT_PGLOST;
            frail_nxt  = lowest_set(8'(lost_c));
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_nxt = ST_UP_WAIT;
                        idx_nxt   = '0;
                    end
                end
                ST_UP_WAIT: begin
                    // Abort before this rail is enabled: unwind from the previous one.
                    if (stop) begin
                        if (idx == '0) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_DN_WAIT;
                            idx_nxt   = idx - IDX_W'(1);
                        end
                    end else if (dly_hit_c) begin
                        rail_en_nxt = rail_en | sel_mask_c;
                        state_nxt   = ST_PG_WAIT;
                    end else begin
                        cnt_en_c = 1'b1;
                    end
                end
                ST_PG_WAIT: begin
                    if (stop) begin
                        state_nxt = ST_DN_WAIT;
                    end else if (pg_sel_c) begin
                        if (idx == LAST_IDX) begin
                            state_nxt = ST_ON;
                        end else begin
                            state_nxt = ST_UP_WAIT;
                            idx_nxt   = idx + IDX_W'(1);
                        end
                    end else if (tmo_hit_c) begin
                        go_fault_c = 1'b1;
                        code_nxt   = FLT_TIMEOUT;
                        frail_nxt  = idx;
                    end else begin
                        cnt_en_c = 1'b1;
                    end
                end
                ST_ON: begin
                    if (stop) begin
                        state_nxt = ST_DN_WAIT;
                        idx_nxt   = LAST_IDX;
                    end
                end
                ST_DN_WAIT: begin
                    if (dly_hit_c) begin
                        rail_en_nxt = rail_en & ~sel_mask_c;
                        if (idx == '0) state_nxt = ST_IDLE;
                        else           idx_nxt   = idx - IDX_W'(1);
                    end else begin
                        cnt_en_c = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_nxt = ST_IDLE;
                        code_nxt  = FLT_NONE;
                        frail_nxt = '0;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        if (go_fault_c) begin
            state_nxt   = ST_FAULT;
            rail_en_nxt = '0;
        end
        // Every state change or rail step restarts the shared timer.
        cnt_clr_c = (state_nxt != state) || (idx_nxt != idx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            rail_en    <= '0;
            busy       <= 1'b0;
            up         <= 1'b0;
            fault      <= 1'b0;
            fault_code <= '0;
            fault_rail <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            rail_en    <= rail_en_nxt;
            busy       <= (state_nxt inside {ST_UP_WAIT, ST_PG_WAIT, ST_DN_WAIT});
            up         <= (state_nxt == ST_ON);
            fault      <= (state_nxt == ST_FAULT);
            fault_code <= code_nxt;
            fault_rail <= frail_nxt;
        end
    end

endmodule
